// File: rtl/glip_traffic_responder_if.sv
// GLIP FIFO link as seen by the logic-side responder.
// out_* carries host->logic words and in_* carries logic->host words.
interface glip_traffic_responder_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;

   modport master (
      output out_data, out_valid, in_ready,
      input  out_ready, in_data, in_valid
   );
   modport slave (
      input  out_data, out_valid, in_ready,
      output out_ready, in_data, in_valid
   );
endinterface

// File: rtl/glip_traffic_responder.sv
// Command-driven GLIP link responder: a header word selects ECHO, GENERATE or
// CHECK, followed by N words of echo, a counting pattern, or pattern verification.
module glip_traffic_responder #(
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   glip_traffic_responder_if.slave link,
   output logic                    busy,
   output logic [WIDTH-1:0]        last_errors
);
   localparam int CW = WIDTH - 2;

   typedef enum logic [2:0] {
      S_IDLE, S_ECHO, S_DRAIN, S_GEN, S_CHECK, S_REPORT
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [WIDTH-1:0] err_q, err_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic [WIDTH-1:0] in_data_q, in_data_d;
   logic             in_valid_q, in_valid_d;
   logic             out_rdy, out_take, in_take;

   // Reset gating keeps out_ready low while rst is asserted, whatever the state.
   always_comb begin
      out_rdy = 1'b0;
      if (rst) begin
         case (state_q)
            S_IDLE, S_CHECK: out_rdy = 1'b1;
            S_ECHO:          out_rdy = !in_valid_q || link.in_ready;
            default:         out_rdy = 1'b0;
         endcase
      end
   end

   assign out_take = link.out_valid && out_rdy;
   assign in_take  = in_valid_q && link.in_ready;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pat_d      = pat_q;
      err_d      = err_q;
      last_d     = last_q;
      in_data_d  = in_data_q;
      in_valid_d = in_valid_q;
      case (state_q)
         S_IDLE: begin
            if (out_take) begin
               cnt_d = link.out_data[CW-1:0];
               pat_d = '0;
               err_d = '0;
               case (link.out_data[WIDTH-1:WIDTH-2])
                  2'b00:   state_d = S_ECHO;
                  2'b01:   state_d = S_GEN;
                  2'b10:   state_d = S_CHECK;
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_ECHO: begin
            if (in_take) in_valid_d = 1'b0;
            if (out_take) begin
               in_data_d  = link.out_data;
               in_valid_d = 1'b1;
               if (cnt_q == '0) state_d = S_DRAIN;
               else             cnt_d   = cnt_q - 1'b1;
            end
         end
         S_DRAIN: begin
            if (!in_valid_q || link.in_ready) begin
               in_valid_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         S_GEN: begin
            // First GEN cycle only loads the output register; later cycles advance on transfer.
            if (!in_valid_q) begin
               in_valid_d = 1'b1;
               in_data_d  = pat_q;
            end else if (link.in_ready) begin
               if (cnt_q == '0) begin
                  in_valid_d = 1'b0;
                  state_d    = S_IDLE;
               end else begin
                  cnt_d     = cnt_q - 1'b1;
                  pat_d     = pat_q + 1'b1;
                  in_data_d = pat_q + 1'b1;
               end
            end
         end
         S_CHECK: begin
            if (out_take) begin
               pat_d = pat_q + 1'b1;
               if (link.out_data != pat_q && err_q != {WIDTH{1'b1}}) err_d = err_q + 1'b1;
               if (cnt_q == '0) begin
                  state_d    = S_REPORT;
                  in_valid_d = 1'b1;
                  in_data_d  = err_d;
                  last_d     = err_d;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         S_REPORT: begin
            if (in_take) begin
               in_valid_d = 1'b0;
               err_d      = '0;
               state_d    = S_IDLE;
            end
         end
         default: begin
            in_valid_d = 1'b0;
            state_d    = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         pat_q      <= '0;
         err_q      <= '0;
         last_q     <= '0;
         in_data_q  <= '0;
         in_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pat_q      <= pat_d;
         err_q      <= err_d;
         last_q     <= last_d;
         in_data_q  <= in_data_d;
         in_valid_q <= in_valid_d;
      end
   end

   assign link.out_ready = out_rdy;
   assign link.in_data   = in_data_q;
   assign link.in_valid  = in_valid_q;
   assign busy           = (state_q != S_IDLE);
   assign last_errors    = last_q;
endmodule

// File: tb/tb_glip_traffic_responder.sv
// Bench for glip_traffic_responder: directed table, hand-written corner sequences,
// and a random command stream checked against a command-level reference model.
module tb_glip_traffic_responder;
   logic        clk;
   logic        rst;
   logic        busy;
   logic [15:0] last_errors;
   int          tests = 0;
   int          fails = 0;
   int          rdy_mode = 0;   // 0 always ready, 1 toggle, 2 random, 3 held low
   logic [15:0] rx_q[$];
   logic [15:0] host_q[$];
   logic [15:0] exp_q[$];
   logic [15:0] exp_last;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data = '0;

   glip_traffic_responder_if #(.WIDTH(16)) ifc ();

   glip_traffic_responder #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .link(ifc.slave), .busy(busy), .last_errors(last_errors)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         0:       ifc.in_ready = 1'b1;
         1:       ifc.in_ready = !ifc.in_ready;
         2:       ifc.in_ready = 1'($urandom_range(0, 1));
         default: ifc.in_ready = 1'b0;
      endcase
   end

   // Records every logic->host transfer and checks that stalled words stay put.
   always @(negedge clk) begin
      if (!rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid_held", 32'(ifc.in_valid), 32'd1);
            chk("stall_data_held", 32'(ifc.in_data), 32'(prev_data));
         end
         if (ifc.in_valid && ifc.in_ready) rx_q.push_back(ifc.in_data);
         prev_stall = ifc.in_valid && !ifc.in_ready;
         prev_data  = ifc.in_data;
      end
   end

   task automatic push(input logic [15:0] w);
      int t = 0;
      ifc.out_valid = 1'b1;
      ifc.out_data  = w;
      @(negedge clk);
      while (!ifc.out_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (!ifc.out_ready) chk("push_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      ifc.out_valid = 1'b0;
   endtask

   task automatic wait_idle(input int n);
      int t = 0;
      @(negedge clk);
      while ((busy || rx_q.size() < n) && t < 40000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 40000) chk("idle_timeout", 32'd0, 32'd1);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   // Reference: interpret the host word stream command by command.
   task automatic model_run();
      int i = 0;
      int n;
      logic [15:0] h, e;
      exp_q.delete();
      while (i < host_q.size()) begin
         h = host_q[i];
         i++;
         n = int'(h[13:0]) + 1;
         case (h[15:14])
            2'b00: for (int k = 0; k < n; k++) begin exp_q.push_back(host_q[i]); i++; end
            2'b01: for (int k = 0; k < n; k++) exp_q.push_back(16'(k));
            2'b10: begin
               e = '0;
               for (int k = 0; k < n; k++) begin
                  if (host_q[i] != 16'(k)) e++;
                  i++;
               end
               exp_q.push_back(e);
               exp_last = e;
            end
            default: ;
         endcase
      end
   endtask

   typedef struct {
      int          nw;
      logic [15:0] w[6];
      int          ne;
      logic [15:0] e[4];
      logic [15:0] last;
      int          rmode;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int t, bad;
      logic [15:0] hdr, op2;
      tbl[0] = '{5, '{16'h0003, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0}, 4,
                 '{16'h1111, 16'h2222, 16'h3333, 16'h4444}, 16'h0000, 0};
      tbl[1] = '{1, '{16'h4002, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 3,
                 '{16'h0000, 16'h0001, 16'h0002, 16'h0}, 16'h0000, 1};
      tbl[2] = '{5, '{16'h8003, 16'h0000, 16'h0001, 16'h0005, 16'h0003, 16'h0}, 1,
                 '{16'h0001, 16'h0, 16'h0, 16'h0}, 16'h0001, 2};
      tbl[3] = '{1, '{16'hC123, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 0,
                 '{16'h0, 16'h0, 16'h0, 16'h0}, 16'h0001, 0};
      tbl[4] = '{3, '{16'h8001, 16'h0000, 16'h0001, 16'h0, 16'h0, 16'h0}, 1,
                 '{16'h0000, 16'h0, 16'h0, 16'h0}, 16'h0000, 2};
      tbl[5] = '{2, '{16'h0000, 16'hABCD, 16'h0, 16'h0, 16'h0, 16'h0}, 1,
                 '{16'hABCD, 16'h0, 16'h0, 16'h0}, 16'h0000, 1};
      tbl[6] = '{3, '{16'h8001, 16'h0005, 16'h0005, 16'h0, 16'h0, 16'h0}, 1,
                 '{16'h0002, 16'h0, 16'h0, 16'h0}, 16'h0002, 0};

      rst = 1'b0;
      ifc.out_valid = 1'b0;
      ifc.out_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_ready", 32'(ifc.out_ready), 32'd0);
      chk("rst_in_valid", 32'(ifc.in_valid), 32'd0);
      chk("rst_in_data", 32'(ifc.in_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_last_errors", 32'(last_errors), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_out_ready", 32'(ifc.out_ready), 32'd1);
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         rx_q.delete();
         rdy_mode = tbl[i].rmode;
         for (int k = 0; k < tbl[i].nw; k++) begin
            push(tbl[i].w[k]);
            op2 = tbl[i].w[0];
            if (k == 0 && op2[15:14] == 2'b11) chk($sformatf("v%0d_reserved_busy", i), 32'(busy), 32'd0);
         end
         wait_idle(tbl[i].ne);
         chk($sformatf("v%0d_count", i), 32'(rx_q.size()), 32'(tbl[i].ne));
         for (int k = 0; k < tbl[i].ne && k < rx_q.size(); k++)
            chk($sformatf("v%0d_word%0d", i, k), 32'(rx_q[k]), 32'(tbl[i].e[k]));
         chk($sformatf("v%0d_last_errors", i), 32'(last_errors), 32'(tbl[i].last));
      end

      // Echo latency: the word shows up the cycle after it is accepted.
      rdy_mode = 0;
      rx_q.delete();
      push(16'h0000);
      push(16'hBEEF);
      chk("echo_lat_valid", 32'(ifc.in_valid), 32'd1);
      chk("echo_lat_data", 32'(ifc.in_data), 32'hBEEF);
      wait_idle(1);

      // Echo backpressure, then a header pushed while the last word is draining.
      rx_q.delete();
      push(16'h0003);
      push(16'hA001);
      fork
         begin
            push(16'hA002);
            push(16'hA003);
            push(16'hA004);
            push(16'h4000);
         end
         begin
            @(posedge clk);
            #1;
            rdy_mode = 3;
            repeat (5) begin
               @(negedge clk);
               chk("bp_out_ready", 32'(ifc.out_ready), 32'd0);
               chk("bp_in_data", 32'(ifc.in_data), 32'hA002);
            end
            @(posedge clk);
            #1;
            rdy_mode = 0;
         end
      join
      wait_idle(5);
      chk("bp_count", 32'(rx_q.size()), 32'd5);
      exp_q = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'h0000};
      for (int k = 0; k < 5 && k < rx_q.size(); k++)
         chk($sformatf("bp_word%0d", k), 32'(rx_q[k]), 32'(exp_q[k]));

      // Reset in the middle of a GEN run, then a fresh GEN restarts at zero.
      rx_q.delete();
      push(16'h4009);
      t = 0;
      while (rx_q.size() < 2 && t < 100) begin
         @(posedge clk);
         t++;
      end
      if (t >= 100) chk("midrst_timeout", 32'd0, 32'd1);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      chk("midrst_in_valid", 32'(ifc.in_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_count", 32'(rx_q.size()), 32'd2);
      rx_q.delete();
      push(16'h4001);
      wait_idle(2);
      chk("restart_count", 32'(rx_q.size()), 32'd2);
      if (rx_q.size() == 2) begin
         chk("restart_w0", 32'(rx_q[0]), 32'h0000);
         chk("restart_w1", 32'(rx_q[1]), 32'h0001);
      end

      // Maximum-length GEN.
      rx_q.delete();
      push(16'h7FFF);
      wait_idle(16384);
      chk("genmax_count", 32'(rx_q.size()), 32'd16384);
      bad = 0;
      for (int k = 0; k < rx_q.size(); k++) if (rx_q[k] !== 16'(k)) bad++;
      chk("genmax_data_errors", 32'(bad), 32'd0);

      // Random command stream against the reference model, starting from reset.
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      rx_q.delete();
      host_q.delete();
      exp_last = '0;
      for (int c = 0; c < 40; c++) begin
         int n = $urandom_range(1, 6);
         logic [1:0] op = 2'($urandom_range(0, 3));
         hdr = {op, 14'(n - 1)};
         host_q.push_back(hdr);
         if (op == 2'b00) for (int k = 0; k < n; k++) host_q.push_back(16'($urandom));
         if (op == 2'b10)
            for (int k = 0; k < n; k++)
               host_q.push_back(($urandom_range(0, 3) == 0) ? 16'(k) ^ 16'($urandom_range(1, 65535)) : 16'(k));
      end
      model_run();
      rdy_mode = 2;
      foreach (host_q[i]) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         push(host_q[i]);
      end
      wait_idle(exp_q.size());
      chk("rand_count", 32'(rx_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
         chk($sformatf("rand_word%0d", k), 32'(rx_q[k]), 32'(exp_q[k]));
      chk("rand_last_errors", 32'(last_errors), 32'(exp_last));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
